// File: rtl/e_sdclk_seq_pkg.sv
// Shared definitions for the SD clock-control sequencer: state encoding,
// default timing constants and the counter-width helper.
package e_sdclk_seq_pkg;

  localparam int SDCLK_DIV_W      = 8;
  localparam int SDCLK_SETTLE_CYC = 8;
  localparam int SDCLK_STABLE_CYC = 16;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_STARTING = 3'd1,
    ST_READY    = 3'd2,
    ST_RUN      = 3'd3,
    ST_GATE     = 3'd4,
    ST_LOAD     = 3'd5
  } seq_state_e;

  // Width needed to hold the largest counter preset (value - 1).
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/e_sdclk_div_pend.sv
// Pending-divider register: captures host divider writes (last write wins)
// and releases the pending flag when the sequencer enters LOAD, unless a
// new write lands in that same cycle.
module e_sdclk_div_pend
  import e_sdclk_seq_pkg::*;
#(
  parameter int DIV_W = SDCLK_DIV_W
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             div_wr,
  input  logic [DIV_W-1:0] div_wdata,
  input  logic             load_entry,
  output logic             div_pend,
  output logic [DIV_W-1:0] pend_val,
  output logic             pend_next
);

  // Next value of the pending flag, exposed so the top can register seq_busy.
  always_comb begin
    pend_next = div_wr | (div_pend & ~load_entry);
  end

  // Capture a new divider or clear the flag on LOAD entry.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      div_pend <= 1'b0;
      pend_val <= '0;
    end else begin
      div_pend <= pend_next;
      if (div_wr) begin
        pend_val <= div_wdata;
      end
    end
  end

endmodule

// File: rtl/e_sdclk_seq.sv
// SD clock-control sequencer: turns the Clock Control register fields into a
// glitch-safe enable/divider-load sequence. The SD clock is never gated while
// the bus is busy, and the divider only changes while the SD clock is gated.
module e_sdclk_seq
  import e_sdclk_seq_pkg::*;
#(
  parameter int DIV_W      = SDCLK_DIV_W,
  parameter int SETTLE_CYC = SDCLK_SETTLE_CYC,
  parameter int STABLE_CYC = SDCLK_STABLE_CYC
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             int_clk_en_reg,
  input  logic             sd_clk_en_reg,
  input  logic             div_wr,
  input  logic [DIV_W-1:0] div_wdata,
  input  logic             cmd_active_sync2,
  input  logic             dat_active_sync2,
  output logic             int_clock_en,
  output logic             sd_clock_en,
  output logic             load_clock_div,
  output logic [DIV_W-1:0] clk_div,
  output logic             int_clk_stable,
  output logic             seq_busy
);

  localparam int CW = cnt_width(SETTLE_CYC, STABLE_CYC);
  localparam logic [CW-1:0] SETTLE_INIT = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] STABLE_INIT = CW'(STABLE_CYC - 1);

  seq_state_e       state;
  seq_state_e       state_next;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic             load_entry;
  logic             bus_busy;
  logic             div_pend;
  logic [DIV_W-1:0] pend_val;
  logic             pend_next;
  logic             stable_next;
  logic             busy_next;

  e_sdclk_div_pend #(
    .DIV_W (DIV_W)
  ) u_div_pend (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .div_wr     (div_wr),
    .div_wdata  (div_wdata),
    .load_entry (load_entry),
    .div_pend   (div_pend),
    .pend_val   (pend_val),
    .pend_next  (pend_next)
  );

  // Next-state and counter logic; dropping the internal enable aborts to OFF.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_entry = 1'b0;
    bus_busy   = cmd_active_sync2 | dat_active_sync2;
    if (!int_clk_en_reg) begin
      state_next = ST_OFF;
      cnt_next   = '0;
    end else begin
      case (state)
        ST_OFF: begin
          state_next = ST_STARTING;
          cnt_next   = STABLE_INIT;
        end
        ST_STARTING, ST_GATE, ST_LOAD: begin
          if (cnt == '0) begin
            state_next = ST_READY;
          end else begin
            cnt_next = cnt - 1'b1;
          end
        end
        ST_READY: begin
          if (div_pend) begin
            state_next = ST_LOAD;
            cnt_next   = SETTLE_INIT;
            load_entry = 1'b1;
          end else if (sd_clk_en_reg) begin
            state_next = ST_RUN;
          end else begin
            state_next = ST_READY;
          end
        end
        ST_RUN: begin
          if ((div_pend || !sd_clk_en_reg) && !bus_busy) begin
            state_next = ST_GATE;
            cnt_next   = SETTLE_INIT;
          end else begin
            state_next = ST_RUN;
          end
        end
        default: begin
          state_next = ST_OFF;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Decode of the next state for the registered status outputs.
  always_comb begin
    stable_next = (state_next == ST_READY) || (state_next == ST_RUN) ||
                  (state_next == ST_GATE)  || (state_next == ST_LOAD);
    busy_next   = (state_next == ST_STARTING) || (state_next == ST_GATE) ||
                  (state_next == ST_LOAD) || pend_next;
  end

  // State, counter and registered outputs; the load toggle fires once per LOAD entry.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_OFF;
      cnt            <= '0;
      int_clock_en   <= 1'b0;
      sd_clock_en    <= 1'b0;
      int_clk_stable <= 1'b0;
      seq_busy       <= 1'b0;
      load_clock_div <= 1'b0;
      clk_div        <= '0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      int_clock_en   <= (state_next != ST_OFF);
      sd_clock_en    <= (state_next == ST_RUN);
      int_clk_stable <= stable_next;
      seq_busy       <= busy_next;
      if (load_entry) begin
        load_clock_div <= ~load_clock_div;
        clk_div        <= pend_val;
      end
    end
  end

endmodule

// File: tb/tb_e_sdclk_seq.sv
// Self-checking bench for e_sdclk_seq: expected timelines are derived from
// the sequencing rules with plain arithmetic on edge numbers.
module tb_e_sdclk_seq;

  localparam int S = 8;
  localparam int T = 16;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       int_clk_en_reg = 1'b0;
  logic       sd_clk_en_reg = 1'b0;
  logic       div_wr = 1'b0;
  logic [7:0] div_wdata = 8'h00;
  logic       cmd_active_sync2 = 1'b0;
  logic       dat_active_sync2 = 1'b0;
  logic       int_clock_en;
  logic       sd_clock_en;
  logic       load_clock_div;
  logic [7:0] clk_div;
  logic       int_clk_stable;
  logic       seq_busy;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] cur_div = 8'h00;

  e_sdclk_seq #(
    .DIV_W      (8),
    .SETTLE_CYC (S),
    .STABLE_CYC (T)
  ) dut (
    .sys_clk          (sys_clk),
    .rst_n            (rst_n),
    .int_clk_en_reg   (int_clk_en_reg),
    .sd_clk_en_reg    (sd_clk_en_reg),
    .div_wr           (div_wr),
    .div_wdata        (div_wdata),
    .cmd_active_sync2 (cmd_active_sync2),
    .dat_active_sync2 (dat_active_sync2),
    .int_clock_en     (int_clock_en),
    .sd_clock_en      (sd_clock_en),
    .load_clock_div   (load_clock_div),
    .clk_div          (clk_div),
    .int_clk_stable   (int_clk_stable),
    .seq_busy         (seq_busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_checks++;
    if ({int_clock_en, sd_clock_en, load_clock_div, int_clk_stable, seq_busy} !== 5'b00000)
      $display("FAIL reset_levels got %b exp 00000",
               {int_clock_en, sd_clock_en, load_clock_div, int_clk_stable, seq_busy});
    else n_pass++;
    n_checks++;
    if (clk_div !== 8'h00) $display("FAIL reset_clk_div got %h exp 00", clk_div);
    else n_pass++;
    rst_n = 1'b1;
    step();
    n_checks++;
    if (int_clock_en !== 1'b0) $display("FAIL off_idle got %b exp 0", int_clock_en);
    else n_pass++;
  endtask

  // int_clk_en_reg set at cycle 0: enable at edge 1, stable at edge T+1.
  task automatic test_startup();
    int_clk_en_reg = 1'b1;
    for (int k = 1; k <= T + 4; k++) begin
      step();
      n_checks++;
      if (int_clock_en !== 1'b1) $display("FAIL start_en k=%0d got %b exp 1", k, int_clock_en);
      else n_pass++;
      n_checks++;
      if (int_clk_stable !== (k >= T + 1)) $display("FAIL start_stable k=%0d got %b exp %b", k, int_clk_stable, (k >= T + 1));
      else n_pass++;
      n_checks++;
      if (sd_clock_en !== 1'b0) $display("FAIL start_sd k=%0d got %b exp 0", k, sd_clock_en);
      else n_pass++;
      n_checks++;
      if (seq_busy !== (k <= T)) $display("FAIL start_busy k=%0d got %b exp %b", k, seq_busy, (k <= T));
      else n_pass++;
    end
  endtask

  task automatic test_enable();
    sd_clk_en_reg = 1'b1;
    step();
    n_checks++;
    if (sd_clock_en !== 1'b1) $display("FAIL enable_sd got %b exp 1", sd_clock_en);
    else n_pass++;
    step();
    n_checks++;
    if (seq_busy !== 1'b0) $display("FAIL enable_busy got %b exp 0", seq_busy);
    else n_pass++;
  endtask

  // Divider write at cycle 0 while RUN; data path busy for L cycles.
  task automatic test_div_change(input int L, input logic [7:0] d);
    int   g;
    logic prev;
    logic tog;
    g = (L + 1 > 2) ? L + 1 : 2;
    div_wr = 1'b1;
    div_wdata = d;
    dat_active_sync2 = (L > 0);
    for (int k = 1; k <= g + 2 * S + 4; k++) begin
      prev = load_clock_div;
      step();
      tog = load_clock_div ^ prev;
      n_checks++;
      if (sd_clock_en !== !(k >= g && k <= g + 2 * S + 1))
        $display("FAIL div_sd L=%0d k=%0d got %b exp %b", L, k, sd_clock_en, !(k >= g && k <= g + 2 * S + 1));
      else n_pass++;
      n_checks++;
      if (tog !== (k == g + S + 1)) $display("FAIL div_toggle L=%0d k=%0d got %b exp %b", L, k, tog, (k == g + S + 1));
      else n_pass++;
      n_checks++;
      if (clk_div !== ((k >= g + S + 1) ? d : cur_div))
        $display("FAIL div_value L=%0d k=%0d got %h exp %h", L, k, clk_div, ((k >= g + S + 1) ? d : cur_div));
      else n_pass++;
      n_checks++;
      if (seq_busy !== (k <= g + 2 * S)) $display("FAIL div_busy L=%0d k=%0d got %b exp %b", L, k, seq_busy, (k <= g + 2 * S));
      else n_pass++;
      if (k == 1) div_wr = 1'b0;
      if (k == L) dat_active_sync2 = 1'b0;
    end
    cur_div = d;
  endtask

  task automatic test_back_to_back(input logic [7:0] d1, input logic [7:0] d2);
    int   toggles = 0;
    int   low = 0;
    logic prev;
    div_wr = 1'b1;
    div_wdata = d1;
    for (int k = 1; k <= 2 * S + 6; k++) begin
      prev = load_clock_div;
      step();
      if (load_clock_div !== prev) toggles++;
      if (sd_clock_en === 1'b0) low++;
      if (k == 1) div_wdata = d2;
      if (k == 2) div_wr = 1'b0;
      if (k == S + 3) begin
        n_checks++;
        if (clk_div !== d2) $display("FAIL b2b_value got %h exp %h", clk_div, d2);
        else n_pass++;
      end
    end
    n_checks++;
    if (toggles != 1) $display("FAIL b2b_toggles got %0d exp 1", toggles);
    else n_pass++;
    n_checks++;
    if (low != 2 * S + 2) $display("FAIL b2b_low got %0d exp %0d", low, 2 * S + 2);
    else n_pass++;
    cur_div = d2;
  endtask

  // Second write lands on the LOAD-entry edge: a second LOAD must follow.
  task automatic test_write_at_load(input logic [7:0] d1, input logic [7:0] d2);
    int   toggles = 0;
    int   low = 0;
    logic prev;
    div_wr = 1'b1;
    div_wdata = d1;
    for (int k = 1; k <= 3 * S + 7; k++) begin
      prev = load_clock_div;
      step();
      if (load_clock_div !== prev) toggles++;
      if (sd_clock_en === 1'b0) low++;
      n_checks++;
      if (((load_clock_div ^ prev) & sd_clock_en) !== 1'b0) $display("FAIL wal_toggle_while_on k=%0d got 1 exp 0", k);
      else n_pass++;
      if (k == S + 3) begin
        n_checks++;
        if (clk_div !== d1) $display("FAIL wal_first got %h exp %h", clk_div, d1);
        else n_pass++;
      end
      if (k == 2 * S + 4) begin
        n_checks++;
        if (clk_div !== d2) $display("FAIL wal_second got %h exp %h", clk_div, d2);
        else n_pass++;
      end
      if (k == 3 * S + 5) begin
        n_checks++;
        if (sd_clock_en !== 1'b1) $display("FAIL wal_run got %b exp 1", sd_clock_en);
        else n_pass++;
      end
      if (k == 1) div_wr = 1'b0;
      if (k == S + 2) begin
        div_wr = 1'b1;
        div_wdata = d2;
      end
      if (k == S + 3) div_wr = 1'b0;
    end
    n_checks++;
    if (toggles != 2) $display("FAIL wal_toggles got %0d exp 2", toggles);
    else n_pass++;
    n_checks++;
    if (low != 3 * S + 3) $display("FAIL wal_low got %0d exp %0d", low, 3 * S + 3);
    else n_pass++;
    cur_div = d2;
  endtask

  // Abort in RUN with a simultaneous write; the write must survive the abort.
  task automatic test_abort(input logic [7:0] d);
    logic prev;
    int_clk_en_reg = 1'b0;
    div_wr = 1'b1;
    div_wdata = d;
    step();
    div_wr = 1'b0;
    n_checks++;
    if ({int_clock_en, sd_clock_en, int_clk_stable} !== 3'b000)
      $display("FAIL abort_levels got %b exp 000", {int_clock_en, sd_clock_en, int_clk_stable});
    else n_pass++;
    step();
    int_clk_en_reg = 1'b1;
    for (int k = 1; k <= T + S + 4; k++) begin
      prev = load_clock_div;
      step();
      n_checks++;
      if ((load_clock_div ^ prev) !== (k == T + 2))
        $display("FAIL abort_toggle k=%0d got %b exp %b", k, load_clock_div ^ prev, (k == T + 2));
      else n_pass++;
      n_checks++;
      if (sd_clock_en !== (k >= T + S + 3)) $display("FAIL abort_sd k=%0d got %b exp %b", k, sd_clock_en, (k >= T + S + 3));
      else n_pass++;
    end
    n_checks++;
    if (clk_div !== d) $display("FAIL abort_kept got %h exp %h", clk_div, d);
    else n_pass++;
    cur_div = d;
  endtask

  // Reset pulse while in LOAD: outputs clear without waiting for an edge.
  task automatic test_reset_mid(input logic [7:0] d);
    div_wr = 1'b1;
    div_wdata = d;
    step();
    div_wr = 1'b0;
    for (int k = 2; k <= S + 3; k++) step();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({int_clock_en, sd_clock_en, load_clock_div, int_clk_stable, seq_busy} !== 5'b00000)
      $display("FAIL rstmid_levels got %b exp 00000",
               {int_clock_en, sd_clock_en, load_clock_div, int_clk_stable, seq_busy});
    else n_pass++;
    n_checks++;
    if (clk_div !== 8'h00) $display("FAIL rstmid_div got %h exp 00", clk_div);
    else n_pass++;
    cur_div = 8'h00;
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= T + 3; k++) begin
      step();
      n_checks++;
      if (int_clk_stable !== (k >= T + 1)) $display("FAIL rstmid_stable k=%0d got %b exp %b", k, int_clk_stable, (k >= T + 1));
      else n_pass++;
      n_checks++;
      if (sd_clock_en !== (k >= T + 2)) $display("FAIL rstmid_sd k=%0d got %b exp %b", k, sd_clock_en, (k >= T + 2));
      else n_pass++;
    end
    n_checks++;
    if (clk_div !== cur_div) $display("FAIL rstmid_div_after got %h exp %h", clk_div, cur_div);
    else n_pass++;
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    test_reset();
    test_startup();
    test_enable();
    test_div_change(0, 8'h04);
    test_div_change(50, 8'h10);
    for (int i = 0; i < 3; i++) begin
      ra = 8'($urandom_range(1, 255));
      if (ra == cur_div) ra = ra ^ 8'h80;
      test_div_change(int'($urandom_range(0, 40)), ra);
    end
    ra = 8'h01;
    rb = 8'h02;
    test_back_to_back(ra, rb);
    ra = 8'($urandom_range(1, 127));
    rb = 8'($urandom_range(128, 255));
    test_back_to_back(ra, rb);
    ra = 8'h03;
    rb = 8'h08;
    test_write_at_load(ra, rb);
    ra = 8'($urandom_range(16, 255));
    test_abort(ra);
    test_reset_mid(8'h55);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
